// File: rtl/demux32_1x2_reg.sv
// ---------------------------------------------------------------------------
// demux32_1x2_reg
//   Registered 1-to-2 demultiplexer with valid/ready handshakes. One producer
//   stream is steered, word by word, to one of two consumer ports chosen by
//   in_select. Each output owns a one-entry holding register and a
//   free-running delivery counter.
//
// Ports
//   clk        : rising-edge clock
//   rst_n      : synchronous active-low reset
//   in_data    : producer word (WIDTH)
//   in_select  : destination, 0 -> out1, 1 -> out2
//   in_valid   : producer presents a word
//   in_ready   : block accepts the word this cycle (combinational)
//   outK_data  : holding register K (WIDTH)
//   outK_valid : holding register K full
//   outK_ready : consumer K takes outK_data this cycle
//   outK_count : words delivered on outK (CNT_W, wraps)
//
// Slot state (one per output)
//   state    | meaning
//   ---------+--------------------------------------------------
//   ST_EMPTY | holding register has no word, outK_valid = 0
//   ST_FULL  | holding register presents a word, outK_valid = 1
// ---------------------------------------------------------------------------
module demux32_1x2_reg #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_select,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [WIDTH-1:0] out2_data,
  output logic             out2_valid,
  input  logic             out2_ready,
  output logic [CNT_W-1:0] out1_count,
  output logic [CNT_W-1:0] out2_count
);

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  logic [0:0]       slot1_q, slot1_d;
  logic [0:0]       slot2_q, slot2_d;
  logic [WIDTH-1:0] data1_q, data1_d;
  logic [WIDTH-1:0] data2_q, data2_d;
  logic [CNT_W-1:0] cnt1_q,  cnt1_d;
  logic [CNT_W-1:0] cnt2_q,  cnt2_d;

  logic deliver1, deliver2;
  logic free1, free2;
  logic accept, load1, load2;

  assign deliver1 = (slot1_q == ST_FULL) & out1_ready;
  assign deliver2 = (slot2_q == ST_FULL) & out2_ready;

  // A slot can take a word if it is empty or is being drained this cycle;
  // only the selected slot gates the producer.
  assign free1 = (slot1_q == ST_EMPTY) | out1_ready;
  assign free2 = (slot2_q == ST_EMPTY) | out2_ready;

  assign in_ready = in_select ? free2 : free1;
  assign accept   = in_valid & in_ready;
  assign load1    = accept & ~in_select;
  assign load2    = accept &  in_select;

  // Slot 1 next state
  always_comb begin
    slot1_d = slot1_q;
    data1_d = data1_q;
    case (slot1_q)
      ST_EMPTY: begin
        if (load1) begin
          slot1_d = ST_FULL;
          data1_d = in_data;
        end
      end
      ST_FULL: begin
        // load1 can only happen here together with deliver1 (refill)
        if (load1) begin
          data1_d = in_data;
        end else if (deliver1) begin
          slot1_d = ST_EMPTY;
        end
      end
      default: slot1_d = ST_EMPTY;
    endcase
  end

  // Slot 2 next state
  always_comb begin
    slot2_d = slot2_q;
    data2_d = data2_q;
    case (slot2_q)
      ST_EMPTY: begin
        if (load2) begin
          slot2_d = ST_FULL;
          data2_d = in_data;
        end
      end
      ST_FULL: begin
        if (load2) begin
          data2_d = in_data;
        end else if (deliver2) begin
          slot2_d = ST_EMPTY;
        end
      end
      default: slot2_d = ST_EMPTY;
    endcase
  end

  // Delivery counters wrap silently
  always_comb begin
    cnt1_d = cnt1_q + {{(CNT_W-1){1'b0}}, deliver1};
    cnt2_d = cnt2_q + {{(CNT_W-1){1'b0}}, deliver2};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot1_q <= ST_EMPTY;
      slot2_q <= ST_EMPTY;
      data1_q <= '0;
      data2_q <= '0;
      cnt1_q  <= '0;
      cnt2_q  <= '0;
    end else begin
      slot1_q <= slot1_d;
      slot2_q <= slot2_d;
      data1_q <= data1_d;
      data2_q <= data2_d;
      cnt1_q  <= cnt1_d;
      cnt2_q  <= cnt2_d;
    end
  end

  assign out1_valid = (slot1_q == ST_FULL);
  assign out2_valid = (slot2_q == ST_FULL);
  assign out1_data  = data1_q;
  assign out2_data  = data2_q;
  assign out1_count = cnt1_q;
  assign out2_count = cnt2_q;

endmodule

// File: tb/tb_demux32_1x2_reg.sv
module tb_demux32_1x2_reg;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_select = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] out1_data, out2_data;
  logic        out1_valid, out2_valid;
  logic        out1_ready = 1'b0;
  logic        out2_ready = 1'b0;
  logic [15:0] out1_count, out2_count;

  // narrow-counter instance for the wrap case
  logic [31:0] s_in_data = '0;
  logic        s_in_select = 1'b0;
  logic        s_in_valid = 1'b0;
  logic        s_in_ready;
  logic [31:0] s_out1_data, s_out2_data;
  logic        s_out1_valid, s_out2_valid;
  logic        s_out1_ready = 1'b0;
  logic        s_out2_ready = 1'b0;
  logic [3:0]  s_out1_count, s_out2_count;

  always #5 clk = ~clk;

  demux32_1x2_reg #(.WIDTH(32), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_select(in_select), .in_valid(in_valid), .in_ready(in_ready),
    .out1_data(out1_data), .out1_valid(out1_valid), .out1_ready(out1_ready),
    .out2_data(out2_data), .out2_valid(out2_valid), .out2_ready(out2_ready),
    .out1_count(out1_count), .out2_count(out2_count)
  );

  demux32_1x2_reg #(.WIDTH(32), .CNT_W(4)) dut_small (
    .clk(clk), .rst_n(rst_n),
    .in_data(s_in_data), .in_select(s_in_select), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .out1_data(s_out1_data), .out1_valid(s_out1_valid), .out1_ready(s_out1_ready),
    .out2_data(s_out2_data), .out2_valid(s_out2_valid), .out2_ready(s_out2_ready),
    .out1_count(s_out1_count), .out2_count(s_out2_count)
  );

  int n_vec = 0;
  int n_err = 0;

  // reference model: expected slot contents and delivery counts
  logic [31:0] q1[$];
  logic [31:0] q2[$];
  logic        m_v1 = 1'b0, m_v2 = 1'b0;
  logic [15:0] m_c1 = '0, m_c2 = '0;
  logic        last_acc;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0; out1_ready = 1'b0; out2_ready = 1'b0;
    s_in_valid = 1'b0; s_out1_ready = 1'b0; s_out2_ready = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    q1.delete(); q2.delete();
    m_v1 = 1'b0; m_v2 = 1'b0; m_c1 = '0; m_c2 = '0;
  endtask

  // One clock: drive, check against model, advance model, cross the edge.
  task automatic cycle(input logic vld, input logic sel, input logic [31:0] d,
                       input logic r1, input logic r2);
    logic exp_rdy, acc;
    in_valid = vld; in_select = sel; in_data = d; out1_ready = r1; out2_ready = r2;
    #3;
    exp_rdy = sel ? (!m_v2 || r2) : (!m_v1 || r1);
    chk("in_ready",   32'(in_ready),   32'(exp_rdy));
    chk("out1_valid", 32'(out1_valid), 32'(m_v1));
    chk("out2_valid", 32'(out2_valid), 32'(m_v2));
    chk("out1_count", 32'(out1_count), 32'(m_c1));
    chk("out2_count", 32'(out2_count), 32'(m_c2));
    if (m_v1) chk("out1_data", out1_data, q1[0]);
    if (m_v2) chk("out2_data", out2_data, q2[0]);
    acc = vld && exp_rdy;
    if (m_v1 && r1) begin void'(q1.pop_front()); m_c1 = m_c1 + 16'd1; end
    if (m_v2 && r2) begin void'(q2.pop_front()); m_c2 = m_c2 + 16'd1; end
    if (acc && !sel) q1.push_back(d);
    if (acc &&  sel) q2.push_back(d);
    m_v1 = (q1.size() != 0);
    m_v2 = (q2.size() != 0);
    last_acc = acc;
    @(posedge clk); #1;
  endtask

  initial begin
    int sent;
    do_reset();

    // idle after reset, both selects
    cycle(0, 0, 32'h0, 0, 0);
    cycle(0, 1, 32'h0, 0, 0);

    // single word to out1
    cycle(1, 0, 32'hDEADBEEF, 1, 1);
    cycle(0, 0, 32'h0, 1, 1);
    cycle(0, 0, 32'h0, 1, 1);

    // out2 stalled: second word refused until drain, then same-cycle refill
    cycle(1, 1, 32'h11111111, 1, 0);
    cycle(1, 1, 32'h22222222, 1, 0);
    cycle(1, 1, 32'h22222222, 1, 0);
    cycle(1, 1, 32'h22222222, 1, 1);
    cycle(0, 1, 32'h0, 1, 1);
    cycle(0, 1, 32'h0, 1, 1);

    // out2 stalled and full does not block traffic to out1
    cycle(1, 1, 32'h33333333, 1, 0);
    cycle(1, 0, 32'hA5A5A5A5, 1, 0);
    cycle(0, 0, 32'h0, 1, 0);
    cycle(0, 0, 32'h0, 1, 0);
    cycle(0, 0, 32'h0, 1, 1);
    cycle(0, 0, 32'h0, 1, 1);

    // reset with both slots full
    cycle(1, 0, 32'h0BAD0001, 0, 0);
    cycle(1, 1, 32'h0BAD0002, 0, 0);
    do_reset();
    cycle(0, 0, 32'h0, 0, 0);

    // random stream of 0..99
    sent = 0;
    for (int it = 0; it < 3000 && sent < 100; it++) begin
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 32'(sent),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if (last_acc) sent++;
    end
    if (sent != 100) chk("stream_sent", 32'(sent), 32'd100);
    repeat (3) cycle(0, 0, 32'h0, 1, 1);
    chk("count_sum", 32'(out1_count) + 32'(out2_count), 32'd100);

    // narrow counter wraps after 16 deliveries
    do_reset();
    s_in_select = 1'b0; s_out1_ready = 1'b1; s_out2_ready = 1'b1;
    s_in_valid = 1'b1;
    repeat (17) @(posedge clk);
    #1 s_in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    chk("wrap_count", 32'(s_out1_count), 32'd1);
    chk("wrap_valid", 32'(s_out1_valid), 32'd0);
    chk("wrap_count2", 32'(s_out2_count), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/demux32_1x2_reg.md
Name: demux32_1x2_reg

Overview:
Registered 1-to-2 demultiplexer with valid/ready handshakes. It steers one 32-bit producer stream to one of two consumer ports, selected per transfer by in_select. It is the distribution counterpart of the 2X1 select muxes in the multicycle datapath. Typical use is routing one result bus (e.g. ALUOut or memory data) to two independently stalling sinks. Each output has a one-entry holding register and a transfer counter.

Parameters:
WIDTH, 32, data width of in_data/out1_data/out2_data
CNT_W, 16, width of per-output transfer counters

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
in_data  input  WIDTH  data to be steered
in_select  input  1  destination: 0 -> out1, 1 -> out2
in_valid  input  1  producer has a word on in_data/in_select
in_ready  output  1  block accepts the word this cycle
out1_data  output  WIDTH  holding register 1
out1_valid  output  1  holding register 1 full
out1_ready  input  1  consumer 1 takes out1_data this cycle
out2_data  output  WIDTH  holding register 2
out2_valid  output  1  holding register 2 full
out2_ready  input  1  consumer 2 takes out2_data this cycle
out1_count  output  CNT_W  number of words delivered on out1 (out1_valid & out1_ready)
out2_count  output  CNT_W  number of words delivered on out2

Behaviour:
- Reset: when rst_n=0 at a clk edge, the following are cleared on that edge: out1_valid, out2_valid, out1_data, out2_data, out1_count, out2_count. Reset mid-transfer discards held words; no delivery is counted on that edge.
- Slot state per output k, two states:
  - EMPTY (outk_valid=0).
  - FULL (outk_valid=1).
- Drain: deliver_k = outk_valid & outk_ready.
- in_ready is combinational:
  - in_select=0: in_ready = ~out1_valid | out1_ready.
  - in_select=1: in_ready = ~out2_valid | out2_ready.
- Accept: accept = in_valid & in_ready. On accept, in_data is written into the selected slot, which is FULL next cycle.
- Latency: a word accepted at edge N appears on outk_data with outk_valid=1 after edge N. That is one cycle, with no combinational in->out data path.
- Transitions for the selected slot:
  - EMPTY + accept -> FULL.
  - FULL + deliver + accept -> FULL with new data (same-cycle drain and refill, full throughput).
  - FULL + deliver, no accept -> EMPTY.
  - FULL, no deliver -> FULL and data held stable.
- The unselected slot evolves only by its own deliver.
- outk_data must not change while outk_valid=1 and outk_ready=0.
- outk_data value when outk_valid=0 is don't-care. The implementation leaves it unchanged.
- No ordering is guaranteed between out1 and out2. Ordering within each output is preserved.
- in_select and in_data are sampled only on accept. in_valid may drop without accept; no word is lost or duplicated.
- Counters: outk_count increments by 1 on every deliver_k. It wraps from 2^CNT_W-1 to 0 silently.
- Both outputs may deliver in the same cycle. Both counters then increment independently.

Test Plan:
- Reset, then idle -> in_ready=1 for either select; out1_valid=out2_valid=0; counts=0. Assert rst_n=0 with both slots FULL -> both valid=0 and counts=0 after the edge.
- Send 0xDEADBEEF sel=0 with out1_ready=1 -> out1_data=0xDEADBEEF, out1_valid=1 one cycle after accept; out1_count=1 after the next edge; out2 untouched.
- Hold out2_ready=0, send 0x11111111 sel=1, then 0x22222222 sel=1 -> in_ready=0 on the second word; out2_data stays 0x11111111. Raise out2_ready -> 0x11111111 delivered, 0x22222222 accepted the same cycle, then delivered next.
- out2 stalled and FULL, send 0xA5A5A5A5 sel=0 -> accepted, since in_ready depends only on the selected slot; out1 delivers while out2 stays held.
- Stream 0..99 with random sel, random in_valid/out1_ready/out2_ready -> each output sequence equals the in-order subsequence of its selected words; out1_count+out2_count=100.
- CNT_W=4: deliver 17 words on out1 -> out1_count=1 (wrap).
